// File: rtl/hazard_forward_unit.sv
// -----------------------------------------------------------------------------
// hazard_forward_unit
//
// Purpose:
//   Data-hazard logic placed between the decoder and the ID/EX pipeline
//   register. It keeps a small shadow copy of the destination-register
//   metadata for the EX, MEM and WB slots. It compares the sources of the
//   instruction being decoded against that copy and produces:
//     - forwardA / forwardB : operand-mux selects, registered so they are
//                             valid while that instruction sits in EX
//     - stall               : combinational load-use stall
//     - ID_EX_bubble        : registered flag marking an empty EX slot
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   ID_valid            ID slot holds a real instruction
//   ID_rs1 / ID_rs2     source register indices
//   ID_rs1_used/_used   instruction actually reads rs1 / rs2
//   ID_rd               destination register index
//   ID_reg_wen          instruction writes rd
//   ID_mem_read         instruction is a load
//   flush               redirect: kill the ID and EX slots
//   forwardA/forwardB   00 regfile, 01 WB data, 10 EX/MEM ALU result
//   stall               hold PC and IF/ID, bubble ID/EX
//   ID_EX_bubble        EX slot currently holds a bubble
// -----------------------------------------------------------------------------
module hazard_forward_unit #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int ZERO_REG       = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      ID_valid,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rs1,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rs2,
   input  logic                      ID_rs1_used,
   input  logic                      ID_rs2_used,
   input  logic [REG_ADDR_WIDTH-1:0] ID_rd,
   input  logic                      ID_reg_wen,
   input  logic                      ID_mem_read,
   input  logic                      flush,
   output logic [1:0]                forwardA,
   output logic [1:0]                forwardB,
   output logic                      stall,
   output logic                      ID_EX_bubble
);

   localparam logic [REG_ADDR_WIDTH-1:0] ZR = ZERO_REG[REG_ADDR_WIDTH-1:0];

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic                      valid;
      logic [REG_ADDR_WIDTH-1:0] rd;
      logic                      wen;
      logic                      load;
   } slot_t;

   localparam slot_t SLOT_EMPTY = '{valid: 1'b0, rd: '0, wen: 1'b0, load: 1'b0};

   slot_t      r_ex, r_mem, r_wb;
   logic [1:0] r_fwd_a, r_fwd_b;
   logic       r_bubble;

   logic       w_ex_wr, w_mem_wr;
   logic       w_stall;
   logic [1:0] w_fwd_a, w_fwd_b;
   slot_t      w_id_slot;

   // Only a slot that will really write a non-zero register can be a
   // producer; writes to the zero register are discarded by the regfile.
   assign w_ex_wr  = r_ex.valid  && r_ex.wen  && (r_ex.rd  != ZR);
   assign w_mem_wr = r_mem.valid && r_mem.wen && (r_mem.rd != ZR);

   // Load result is not available until the load leaves MEM, so a consumer
   // directly behind it must wait one cycle. A flush makes the consumer dead,
   // so there is nothing to wait for.
   assign w_stall = ID_valid && !flush && w_ex_wr && r_ex.load &&
                    ((ID_rs1_used && (ID_rs1 == r_ex.rd)) ||
                     (ID_rs2_used && (ID_rs2 == r_ex.rd)));

   // Codes are evaluated one stage early: what is in EX now will be in MEM
   // when the decoding instruction reaches EX (select 10), and what is in
   // MEM now will be in WB (select 01). The younger producer wins.
   always_comb begin
      w_fwd_a = FWD_RF;
      w_fwd_b = FWD_RF;
      if (ID_valid) begin
         if (ID_rs1_used && w_ex_wr && (r_ex.rd == ID_rs1))
            w_fwd_a = FWD_MEM;
         else if (ID_rs1_used && w_mem_wr && (r_mem.rd == ID_rs1))
            w_fwd_a = FWD_WB;
         if (ID_rs2_used && w_ex_wr && (r_ex.rd == ID_rs2))
            w_fwd_b = FWD_MEM;
         else if (ID_rs2_used && w_mem_wr && (r_mem.rd == ID_rs2))
            w_fwd_b = FWD_WB;
      end
   end

   assign w_id_slot = '{valid: ID_valid, rd: ID_rd, wen: ID_reg_wen, load: ID_mem_read};

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ex     <= SLOT_EMPTY;
         r_mem    <= SLOT_EMPTY;
         r_wb     <= SLOT_EMPTY;
         r_fwd_a  <= FWD_RF;
         r_fwd_b  <= FWD_RF;
         r_bubble <= 1'b1;
      end else begin
         // Older slots always drain; only the ID->EX transfer is gated.
         r_wb  <= r_mem;
         r_mem <= r_ex;
         if (flush || w_stall) begin
            r_ex     <= SLOT_EMPTY;
            r_fwd_a  <= FWD_RF;
            r_fwd_b  <= FWD_RF;
            r_bubble <= 1'b1;
         end else begin
            r_ex     <= w_id_slot;
            r_fwd_a  <= w_fwd_a;
            r_fwd_b  <= w_fwd_b;
            r_bubble <= !ID_valid;
         end
      end
   end

   assign forwardA     = r_fwd_a;
   assign forwardB     = r_fwd_b;
   assign stall        = w_stall;
   assign ID_EX_bubble = r_bubble;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

   logic       clk = 1'b0;
   logic       reset;
   logic       ID_valid;
   logic [4:0] ID_rs1, ID_rs2, ID_rd;
   logic       ID_rs1_used, ID_rs2_used, ID_reg_wen, ID_mem_read;
   logic       flush;
   logic [1:0] forwardA, forwardB;
   logic       stall, ID_EX_bubble;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [1:0] fa;
      logic [1:0] fb;
      logic       bub;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   hazard_forward_unit #(.REG_ADDR_WIDTH(5), .ZERO_REG(0)) dut (
      .clk(clk), .reset(reset),
      .ID_valid(ID_valid), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
      .ID_rs1_used(ID_rs1_used), .ID_rs2_used(ID_rs2_used),
      .ID_rd(ID_rd), .ID_reg_wen(ID_reg_wen), .ID_mem_read(ID_mem_read),
      .flush(flush),
      .forwardA(forwardA), .forwardB(forwardB),
      .stall(stall), .ID_EX_bubble(ID_EX_bubble)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // One ID cycle: called at negedge. Drives the decoded instruction, checks
   // the combinational stall, pushes the expected registered outputs and
   // pops/compares them once the edge has moved the instruction into EX.
   task automatic issue(input string name, input logic v,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wen, input logic ld,
                        input logic fl, input logic e_stall,
                        input logic [1:0] e_fa, input logic [1:0] e_fb,
                        input logic e_bub);
      exp_t e;
      ID_valid = v; ID_rs1 = rs1; ID_rs1_used = u1; ID_rs2 = rs2; ID_rs2_used = u2;
      ID_rd = rd; ID_reg_wen = wen; ID_mem_read = ld; flush = fl;
      #1;
      checks++;
      if (stall !== e_stall) begin
         errors++;
         $display("FAIL %s stall: got %b expected %b", name, stall, e_stall);
      end
      e.name = name; e.fa = e_fa; e.fb = e_fb; e.bub = e_bub;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if ({forwardA, forwardB, ID_EX_bubble} !== {e.fa, e.fb, e.bub}) begin
         errors++;
         $display("FAIL %s fwdA/fwdB/bubble: got %b/%b/%b expected %b/%b/%b",
                  e.name, forwardA, forwardB, ID_EX_bubble, e.fa, e.fb, e.bub);
      end
   endtask

   task automatic nop(input string name);
      issue(name, 0, 5'd0, 0, 5'd0, 0, 5'd0, 0, 0, 0, 0, 2'b00, 2'b00, 1);
   endtask

   task automatic drain();
      nop("drain0"); nop("drain1"); nop("drain2");
   endtask

   task automatic test_reset();
      // Reset applied while a valid, hazard-looking instruction is presented.
      reset = 1;
      ID_valid = 1; ID_rs1 = 5'd5; ID_rs1_used = 1; ID_rs2 = 5'd5; ID_rs2_used = 1;
      ID_rd = 5'd5; ID_reg_wen = 1; ID_mem_read = 1; flush = 0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      checks++;
      if ({forwardA, forwardB, ID_EX_bubble, stall} !== {2'b00, 2'b00, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL reset_state: got fa=%b fb=%b bub=%b stall=%b expected 00 00 1 0",
                  forwardA, forwardB, ID_EX_bubble, stall);
      end
      reset = 0;
      nop("idle0");
      nop("idle1");
   endtask

   task automatic test_ex_forward();
      drain();
      issue("ex_add_x5",   1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      issue("ex_add_x7",   1, 5'd5, 1, 5'd6, 1, 5'd7, 1, 0, 0, 0, 2'b10, 2'b00, 0);
   endtask

   task automatic test_mem_forward();
      drain();
      issue("mem_add_x5",  1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      nop("mem_gap");
      issue("mem_sub_x8",  1, 5'd1, 1, 5'd5, 1, 5'd8, 1, 0, 0, 0, 2'b00, 2'b01, 0);
      drain();
      issue("old_add_x5",  1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      nop("old_gap0");
      nop("old_gap1");
      issue("old_reader",  1, 5'd5, 1, 5'd5, 1, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      // Producer that does not write (wen=0) is never forwarded.
      drain();
      issue("nowen_x5",    1, 5'd1, 1, 5'd2, 1, 5'd5, 0, 0, 0, 0, 2'b00, 2'b00, 0);
      issue("nowen_rdr",   1, 5'd5, 1, 5'd5, 1, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, 0);
   endtask

   task automatic test_load_use();
      drain();
      issue("lu_lw_x6",    1, 5'd2, 1, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'b00, 2'b00, 0);
      issue("lu_stall",    1, 5'd6, 1, 5'd6, 1, 5'd9, 1, 0, 0, 1, 2'b00, 2'b00, 1);
      issue("lu_retry",    1, 5'd6, 1, 5'd6, 1, 5'd9, 1, 0, 0, 0, 2'b01, 2'b01, 0);
      issue("lu_next_x9",  1, 5'd9, 1, 5'd3, 1, 5'd10, 1, 0, 0, 0, 2'b10, 2'b00, 0);
      // Matching index but operand not actually read: no stall.
      drain();
      issue("lu_lw2_x6",   1, 5'd2, 1, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'b00, 2'b00, 0);
      issue("lu_unused",   1, 5'd6, 0, 5'd6, 0, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, 0);
   endtask

   task automatic test_zero_reg();
      drain();
      issue("z_addi_x0",   1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      issue("z_reader",    1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      drain();
      issue("z_lw_x0",     1, 5'd1, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0, 2'b00, 2'b00, 0);
      issue("z_ld_reader", 1, 5'd0, 1, 5'd0, 1, 5'd3, 1, 0, 0, 0, 2'b00, 2'b00, 0);
   endtask

   task automatic test_youngest_wins();
      drain();
      issue("y_add_x5_a",  1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      issue("y_add_x5_b",  1, 5'd3, 1, 5'd4, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      issue("y_reader",    1, 5'd5, 1, 5'd5, 1, 5'd11, 1, 0, 0, 0, 2'b10, 2'b10, 0);
   endtask

   task automatic test_flush();
      drain();
      issue("f_lw_x6",     1, 5'd2, 1, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'b00, 2'b00, 0);
      issue("f_stall_fl",  1, 5'd6, 1, 5'd6, 1, 5'd9, 1, 0, 1, 0, 2'b00, 2'b00, 1);
      issue("f_after",     1, 5'd6, 1, 5'd6, 1, 5'd9, 1, 0, 0, 0, 2'b01, 2'b01, 0);
      // Flushed EX entry must not shadow the older producer that keeps moving.
      drain();
      issue("f_add_x5",    1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0, 2'b00, 2'b00, 0);
      issue("f_kill",      1, 5'd5, 1, 5'd5, 1, 5'd7, 1, 0, 1, 0, 2'b00, 2'b00, 1);
      issue("f_target",    1, 5'd5, 1, 5'd7, 1, 5'd8, 1, 0, 0, 0, 2'b01, 2'b00, 0);
   endtask

   task automatic test_reset_mid_stall();
      drain();
      issue("r_lw_x6",     1, 5'd2, 1, 5'd0, 0, 5'd6, 1, 1, 0, 0, 2'b00, 2'b00, 0);
      reset = 1;
      issue("r_stall_rst", 1, 5'd6, 1, 5'd6, 1, 5'd9, 1, 0, 0, 1, 2'b00, 2'b00, 1);
      reset = 0;
      issue("r_after",     1, 5'd6, 1, 5'd6, 1, 5'd9, 1, 0, 0, 0, 2'b00, 2'b00, 0);
   endtask

   initial begin
      reset = 1; ID_valid = 0; ID_rs1 = 0; ID_rs2 = 0; ID_rd = 0;
      ID_rs1_used = 0; ID_rs2_used = 0; ID_reg_wen = 0; ID_mem_read = 0; flush = 0;
      @(negedge clk);
      test_reset();
      test_ex_forward();
      test_mem_forward();
      test_load_use();
      test_zero_reg();
      test_youngest_wins();
      test_flush();
      test_reset_mid_stall();
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left expected 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
